// File: rtl/apple_placer.sv
// Picks a random empty cell of the packed field map for the next apple spawn.
// Count empties, reduce rand_val modulo that count by restoring division, then rescan to locate it.
module apple_placer #(
    parameter int SIZE_X = 10,
    parameter int SIZE_Y = 10,
    parameter int RAND_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [RAND_W-1:0]          rand_val,
    input  logic [2*SIZE_X*SIZE_Y-1:0] field,
    output logic                       busy,
    output logic                       done,
    output logic                       found,
    output logic [7:0]                 apple_x,
    output logic [7:0]                 apple_y,
    output logic [15:0]                empty_cnt
);

    localparam int              CELLS    = SIZE_X * SIZE_Y;
    localparam int              FW       = 2 * CELLS;
    localparam int              DCW      = $clog2(RAND_W + 1);
    localparam logic [15:0]     LAST_IDX = 16'(CELLS - 1);
    localparam logic [7:0]      LAST_X   = 8'(SIZE_X - 1);
    localparam logic [DCW-1:0]  LAST_DIV = DCW'(RAND_W - 1);

    typedef enum logic [2:0] {IDLE, COUNT, DIV, PICK, DONE} state_t;

    state_t state, state_next;

    logic [FW-1:0]     field_q;
    logic [RAND_W-1:0] dividend;
    logic [15:0]       rem;
    logic [15:0]       count;
    logic [15:0]       idx;
    logic [15:0]       k;
    logic [7:0]        cur_x, cur_y;
    logic [7:0]        pick_x, pick_y;
    logic              pick_found;
    logic [DCW-1:0]    div_cnt;

    logic              cell_empty;
    logic [15:0]       count_inc;
    logic [16:0]       rem_shift;
    logic [15:0]       rem_sub;
    logic              rem_ge;
    logic              hit;
    logic [FW-1:0]     field_rot;

    // The snapshot rotates by one cell per scan cycle, so a full pass restores it for the rescan.
    assign field_rot  = (field_q >> 2) | (field_q << (FW - 2));
    assign cell_empty = (field_q[1:0] == 2'b00);
    assign count_inc  = count + 16'(cell_empty);
    assign rem_shift  = {rem, dividend[RAND_W-1]};
    assign rem_ge     = (rem_shift >= {1'b0, count});
    assign rem_sub    = rem_shift[15:0] - count;
    assign hit        = cell_empty && (k == rem);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        case (state)
            IDLE:  if (start) state_next = COUNT;
            COUNT: if (idx == LAST_IDX) state_next = (count_inc == 16'd0) ? DONE : DIV;
            DIV:   if (div_cnt == LAST_DIV) state_next = PICK;
            PICK:  if (hit || idx == LAST_IDX) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            field_q    <= '0;
            dividend   <= '0;
            rem        <= '0;
            count      <= '0;
            idx        <= '0;
            k          <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            pick_x     <= '0;
            pick_y     <= '0;
            pick_found <= 1'b0;
            div_cnt    <= '0;
            done       <= 1'b0;
            found      <= 1'b0;
            apple_x    <= '0;
            apple_y    <= '0;
            empty_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    field_q    <= field;
                    dividend   <= rand_val;
                    rem        <= '0;
                    count      <= '0;
                    idx        <= '0;
                    k          <= '0;
                    cur_x      <= '0;
                    cur_y      <= '0;
                    div_cnt    <= '0;
                    pick_found <= 1'b0;
                end
                COUNT: begin
                    field_q <= field_rot;
                    count   <= count_inc;
                    idx     <= (idx == LAST_IDX) ? 16'd0 : idx + 16'd1;
                end
                DIV: begin
                    rem      <= rem_ge ? rem_sub : rem_shift[15:0];
                    dividend <= dividend << 1;
                    div_cnt  <= div_cnt + DCW'(1);
                end
                PICK: begin
                    field_q <= field_rot;
                    idx     <= idx + 16'd1;
                    if (cur_x == LAST_X) begin
                        cur_x <= '0;
                        cur_y <= cur_y + 8'd1;
                    end else begin
                        cur_x <= cur_x + 8'd1;
                    end
                    if (hit) begin
                        pick_found <= 1'b1;
                        pick_x     <= cur_x;
                        pick_y     <= cur_y;
                    end else if (cell_empty) begin
                        k <= k + 16'd1;
                    end
                end
                DONE: begin
                    done      <= 1'b1;
                    found     <= pick_found;
                    apple_x   <= pick_found ? pick_x : 8'd0;
                    apple_y   <= pick_found ? pick_y : 8'd0;
                    empty_cnt <= count;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apple_placer.sv
// Directed bench for apple_placer on a 10x10 field with hand-computed cells, counts and latencies.
module tb_apple_placer;

    localparam int FW = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   rand_val;
    logic [FW-1:0] field;
    logic          busy, done, found;
    logic [7:0]    apple_x, apple_y;
    logic [15:0]   empty_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [FW-1:0] f_empty, f_full, f_t3, f_last;
    int lat, busy_cnt, extra_done, seen;

    apple_placer #(.SIZE_X(10), .SIZE_Y(10), .RAND_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .rand_val(rand_val), .field(field),
        .busy(busy), .done(done), .found(found),
        .apple_x(apple_x), .apple_y(apple_y), .empty_cnt(empty_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Start a request, optionally disturb field / re-pulse start mid-flight, wait for done.
    task automatic applyStimulus(input logic [FW-1:0] f, input logic [15:0] rv,
                                 input logic [FW-1:0] alt_f, input int alt_cyc,
                                 input int restart_cyc,
                                 output int lat_o, output int busy_o, output int extra_o);
        int done_seen;
        field = f;
        rand_val = rv;
        start = 1'b1;
        lat_o = 0;
        busy_o = 0;
        extra_o = 0;
        done_seen = 0;
        while (done_seen == 0 && lat_o < 400) begin
            @(posedge clk); #1;
            lat_o++;
            start = (lat_o == restart_cyc);
            if (lat_o == alt_cyc) field = alt_f;
            if (done) done_seen = 1;
            else if (busy) busy_o++;
        end
        start = 1'b0;
        checkOutput("done_seen", done_seen, 1);
        repeat (3) begin
            @(posedge clk); #1;
            if (done) extra_o++;
        end
    endtask

    task automatic checkResult(input string tag, input int exp_found, input int exp_x,
                               input int exp_y, input int exp_cnt, input int exp_lat);
        checkOutput({tag, "_found"}, int'(found), exp_found);
        checkOutput({tag, "_x"}, int'(apple_x), exp_x);
        checkOutput({tag, "_y"}, int'(apple_y), exp_y);
        checkOutput({tag, "_cnt"}, int'(empty_cnt), exp_cnt);
        checkOutput({tag, "_lat"}, lat, exp_lat);
        checkOutput({tag, "_busy"}, busy_cnt, exp_lat - 1);
        checkOutput({tag, "_extra"}, extra_done, 0);
    endtask

    initial begin
        f_empty = '0;
        f_full  = '0;
        f_t3    = '0;
        f_last  = '0;
        for (int i = 0; i < 100; i++) begin
            f_full[2*i +: 2] = (i % 2 == 0) ? 2'b01 : 2'b11;
            f_last[2*i +: 2] = 2'b01;
        end
        f_last[198 +: 2] = 2'b00;
        for (int i = 0; i < 5; i++) f_t3[2*i +: 2] = 2'b01;
        f_t3[14 +: 2] = 2'b11;

        rst = 1'b1;
        start = 1'b0;
        rand_val = '0;
        field = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_found", int'(found), 0);
        checkOutput("rst_xy", int'({apple_x, apple_y}), 0);
        checkOutput("rst_cnt", int'(empty_cnt), 0);
        rst = 1'b0;

        applyStimulus(f_empty, 16'd0, '0, 0, 0, lat, busy_cnt, extra_done);
        checkResult("empty_r0", 1, 0, 0, 100, 119);
        checkOutput("hold_found", int'(found), 1);

        applyStimulus(f_empty, 16'd23, '0, 0, 0, lat, busy_cnt, extra_done);
        checkResult("empty_r23", 1, 3, 2, 100, 142);

        applyStimulus(f_empty, 16'd205, '0, 0, 0, lat, busy_cnt, extra_done);
        checkResult("empty_r205", 1, 5, 0, 100, 124);

        applyStimulus(f_t3, 16'd0, '0, 0, 0, lat, busy_cnt, extra_done);
        checkResult("t3_r0", 1, 5, 0, 94, 124);

        applyStimulus(f_t3, 16'd2, '0, 0, 0, lat, busy_cnt, extra_done);
        checkResult("t3_r2", 1, 8, 0, 94, 127);

        applyStimulus(f_full, 16'd37, '0, 0, 0, lat, busy_cnt, extra_done);
        checkResult("full", 0, 0, 0, 0, 102);

        applyStimulus(f_last, 16'hFFFF, '0, 0, 0, lat, busy_cnt, extra_done);
        checkResult("last_cell", 1, 9, 9, 1, 218);

        // Field flips to fully occupied and start re-pulses while the request is in flight.
        applyStimulus(f_empty, 16'd23, f_full, 3, 50, lat, busy_cnt, extra_done);
        checkResult("snapshot", 1, 3, 2, 100, 142);

        // Reset in the middle of PICK for target 50 (PICK spans cycles 117..167).
        field = f_empty;
        rand_val = 16'd50;
        start = 1'b1;
        seen = 0;
        for (int c = 1; c <= 130; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) seen++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("pick_rst_busy", int'(busy), 0);
        checkOutput("pick_rst_found", int'(found), 0);
        checkOutput("pick_rst_cnt", int'(empty_cnt), 0);
        repeat (3) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        checkOutput("pick_rst_no_done", seen, 0);

        applyStimulus(f_empty, 16'd7, '0, 0, 0, lat, busy_cnt, extra_done);
        checkResult("after_rst", 1, 7, 0, 100, 126);

        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        checkOutput("rst_start_busy0", int'(busy), 0);
        @(posedge clk); #1;
        checkOutput("rst_start_busy1", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
